// File: rtl/simple_bus_pkg.sv
// Shared types and constants for the simple bus register-file slave.
package simple_bus_pkg;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ERR_RDATA = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/bus_regfile_mem.sv
// DEPTH x DATA_WIDTH register storage: synchronous write, combinational read.
module bus_regfile_mem #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array, cleared on reset, written when we is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simple_bus_regfile_slave.sv
// Register-file slave with programmable wait states and a trailing HOLD
// cycle that swallows the extra valid cycle driven by the upstream bridge.
module simple_bus_regfile_slave
  import simple_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_we,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_we;

  logic                  commit_c;
  logic [ADDR_WIDTH-1:0] acc_addr_c;
  logic [DATA_WIDTH-1:0] acc_wdata_c;
  logic                  acc_we_c;
  logic                  in_range_c;
  logic                  mem_we_c;
  logic [DATA_WIDTH-1:0] mem_rdata_c;

  // Select the access operands: live inputs on a zero-wait capture, else the
  // request registers; flag the edge that commits the access.
  always_comb begin
    acc_addr_c  = req_addr;
    acc_wdata_c = req_wdata;
    acc_we_c    = req_we;
    commit_c    = 1'b0;
    if (state == IDLE) begin
      acc_addr_c  = s_addr;
      acc_wdata_c = s_wdata;
      acc_we_c    = s_we;
      commit_c    = s_valid && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      commit_c = (cnt == CNT_W'(1));
    end
    in_range_c = {1'b0, acc_addr_c} < (ADDR_WIDTH + 1)'(DEPTH);
    mem_we_c   = commit_c && acc_we_c && in_range_c;
  end

  bus_regfile_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (mem_we_c),
    .waddr   (acc_addr_c[IDX_W-1:0]),
    .wdata   (acc_wdata_c),
    .raddr   (acc_addr_c[IDX_W-1:0]),
    .rdata   (mem_rdata_c)
  );

  // Request FSM, wait counter, request capture and registered response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
      s_ready   <= 1'b0;
      s_err     <= 1'b0;
      s_rdata   <= '0;
    end else begin
      if (commit_c) begin
        s_ready <= 1'b1;
        s_err   <= !in_range_c;
        if (!in_range_c) begin
          s_rdata <= DATA_WIDTH'(ERR_RDATA);
        end else if (!acc_we_c) begin
          s_rdata <= mem_rdata_c;
        end
      end
      case (state)
        IDLE: begin
          if (s_valid) begin
            req_addr  <= s_addr;
            req_wdata <= s_wdata;
            req_we    <= s_we;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state   <= HOLD;
          s_ready <= 1'b0;
          s_err   <= 1'b0;
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_bus_regfile_slave.sv
// Scoreboard bench: a WAIT_STATES=2 and a WAIT_STATES=0 instance, directed
// requests push expected responses, a monitor checks every s_ready pulse.
module tb_simple_bus_regfile_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        v2 = 1'b0;
  logic        v0 = 1'b0;
  logic        rdy2, err2, rdy0, err0;
  logic [31:0] rd2, rd0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  simple_bus_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .s_addr(addr), .s_wdata(wdata), .s_we(we),
    .s_valid(v2), .s_ready(rdy2), .s_rdata(rd2), .s_err(err2)
  );

  simple_bus_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .s_addr(addr), .s_wdata(wdata), .s_we(we),
    .s_valid(v0), .s_ready(rdy0), .s_rdata(rd0), .s_err(err0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response must match the head of its scoreboard queue.
  always @(negedge clk) begin
    checks++;
    if (rdy2) begin
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL ws2_spurious_ready cyc=%0d: got ready with rdata=%h err=%b, required no response", cyc, rd2, err2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        if (cyc != e.cyc || rd2 !== e.rdata || err2 !== e.err) begin
          errors++;
          $display("FAIL ws2_resp: got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                   cyc, rd2, err2, e.cyc, e.rdata, e.err);
        end
      end
    end else if (err2 !== 1'b0) begin
      errors++;
      $display("FAIL ws2_err_idle cyc=%0d: got err=%b, required 0", cyc, err2);
    end
    checks++;
    if (rdy0) begin
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL ws0_spurious_ready cyc=%0d: got ready with rdata=%h err=%b, required no response", cyc, rd0, err0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (cyc != e.cyc || rd0 !== e.rdata || err0 !== e.err) begin
          errors++;
          $display("FAIL ws0_resp: got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                   cyc, rd0, err0, e.cyc, e.rdata, e.err);
        end
      end
    end else if (err0 !== 1'b0) begin
      errors++;
      $display("FAIL ws0_err_idle cyc=%0d: got err=%b, required 0", cyc, err0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Issue one request held for 'hold' sampling edges; push the first response.
  task automatic req(input bit sel0, input logic [7:0] a, input logic [31:0] d, input logic w,
                     input int hold, input logic [31:0] er, input logic ee, output int e);
    exp_t x;
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = w;
    if (sel0) v0 = 1'b1;
    else      v2 = 1'b1;
    e       = cyc + 1;
    x.rdata = er;
    x.err   = ee;
    if (sel0) begin
      x.cyc = e;
      q0.push_back(x);
    end else begin
      x.cyc = e + 2;
      q2.push_back(x);
    end
    repeat (hold) @(negedge clk);
    v0    = 1'b0;
    v2    = 1'b0;
    addr  = 8'h06;
    wdata = 32'hDEAD_BEEF;
    we    = 1'b1;
  endtask

  // Wait (bounded) for all expected responses, then idle to catch extra pulses.
  task automatic drain();
    int n;
    n = 0;
    while ((q2.size() != 0 || q0.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q2.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL response_timeout: got %0d/%0d pending responses, required 0/0", q2.size(), q0.size());
      q2.delete();
      q0.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    exp_t x;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("reset_ready2", 32'(rdy2), 32'd0);
    chk("reset_err2",   32'(err2), 32'd0);
    chk("reset_rdata2", rd2,       32'd0);
    chk("reset_ready0", 32'(rdy0), 32'd0);
    chk("reset_rdata0", rd0,       32'd0);

    req(1'b0, 8'd3, 32'h0, 1'b0, 1, 32'h0, 1'b0, e); drain();
    req(1'b0, 8'd5, 32'hA5A5_0001, 1'b1, 1, 32'h0, 1'b0, e); drain();
    req(1'b0, 8'd5, 32'h0, 1'b0, 1, 32'hA5A5_0001, 1'b0, e); drain();
    req(1'b0, 8'd6, 32'h0, 1'b0, 1, 32'h0, 1'b0, e); drain();

    // Valid held through RESP and HOLD like the bridge: exactly one response.
    req(1'b0, 8'd5, 32'h0, 1'b0, 5, 32'hA5A5_0001, 1'b0, e); drain();

    // Valid held one edge longer: recaptured at E+5, response at E+7.
    req(1'b0, 8'd5, 32'h0, 1'b0, 6, 32'hA5A5_0001, 1'b0, e);
    x.cyc = e + 7; x.rdata = 32'hA5A5_0001; x.err = 1'b0;
    q2.push_back(x);
    drain();

    req(1'b0, 8'd0,  32'h0000_00C3, 1'b1, 1, 32'hA5A5_0001, 1'b0, e); drain();
    req(1'b0, 8'd16, 32'hFFFF_FFFF, 1'b1, 1, 32'h0,         1'b1, e); drain();
    req(1'b0, 8'd0,  32'h0,         1'b0, 1, 32'h0000_00C3, 1'b0, e); drain();
    req(1'b0, 8'hFF, 32'h0,         1'b0, 1, 32'h0,         1'b1, e); drain();
    req(1'b0, 8'd0,  32'h0,         1'b0, 1, 32'h0000_00C3, 1'b0, e); drain();

    req(1'b1, 8'd1, 32'h0000_0055, 1'b1, 1, 32'h0,         1'b0, e); drain();
    req(1'b1, 8'd1, 32'h0,         1'b0, 1, 32'h0000_0055, 1'b0, e); drain();
    req(1'b1, 8'd1, 32'h0,         1'b0, 3, 32'h0000_0055, 1'b0, e); drain();

    // Reset during WAIT of a write to addr 2: no response, no write.
    @(negedge clk);
    addr = 8'd2; wdata = 32'h1234_5678; we = 1'b1; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_ready2", 32'(rdy2), 32'd0);
    chk("abort_rdata2", rd2,       32'd0);
    chk("abort_rdata0", rd0,       32'd0);
    @(negedge clk) reset_n = 1'b1;
    req(1'b0, 8'd2, 32'h0, 1'b0, 1, 32'h0, 1'b0, e); drain();
    req(1'b0, 8'd0, 32'h0, 1'b0, 1, 32'h0, 1'b0, e); drain();
    req(1'b0, 8'd5, 32'h0, 1'b0, 1, 32'h0, 1'b0, e); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
